// File: rtl/four_bit_ds_pkg.sv
// Shared definitions for the four-channel data selector: select encodings
// and the default counter width.
package four_bit_ds_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } sel_e;

endpackage

// File: rtl/four_bit_ds_if.sv
// Signal bundle for four_bit_ds: data/select/control inputs plus all results.
interface four_bit_ds_if #(
  parameter int unsigned CNT_W = four_bit_ds_pkg::CNT_W_DEF
);
  logic             A, B, C, D;
  logic             E0, E1;
  logic             en, clr;
  logic             F, F_q;
  logic [1:0]       sel_q;
  logic             sel_chg;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;

  modport master (
    output A, B, C, D, E0, E1, en, clr,
    input  F, F_q, sel_q, sel_chg, cnt_a, cnt_b, cnt_c, cnt_d
  );

  modport slave (
    input  A, B, C, D, E0, E1, en, clr,
    output F, F_q, sel_q, sel_chg, cnt_a, cnt_b, cnt_c, cnt_d
  );
endinterface

// File: rtl/ds_sat_counter.sv
// Saturating up-counter with synchronous clear (priority over inc) and
// asynchronous active-high reset.
module ds_sat_counter #(
  parameter int unsigned CNT_W = four_bit_ds_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/four_bit_ds.sv
// Four-to-one data selector with registered output/select, select-change
// pulse and per-channel saturating selection counters.
module four_bit_ds
  import four_bit_ds_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E0,
  input  logic             E1,
  input  logic             en,
  input  logic             clr,
  output logic             F,
  output logic             F_q,
  output logic [1:0]       sel_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
);

  sel_e sel;
  logic inc_a, inc_b, inc_c, inc_d;

  assign sel = sel_e'({E0, E1});

  // Pure combinational path: valid with no clock and during reset.
  always_comb begin
    F = 1'b0;
    unique case (sel)
      SEL_A: F = A;
      SEL_B: F = B;
      SEL_C: F = C;
      SEL_D: F = D;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_q     <= 1'b0;
      sel_q   <= SEL_A;
      sel_chg <= 1'b0;
    end else begin
      F_q     <= F;
      sel_q   <= sel;
      sel_chg <= (sel != sel_q);
    end
  end

  assign inc_a = en && (sel == SEL_A);
  assign inc_b = en && (sel == SEL_B);
  assign inc_c = en && (sel == SEL_C);
  assign inc_d = en && (sel == SEL_D);

  ds_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst(rst), .inc(inc_a), .clr(clr), .cnt(cnt_a)
  );
  ds_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst(rst), .inc(inc_b), .clr(clr), .cnt(cnt_b)
  );
  ds_sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
    .clk(clk), .rst(rst), .inc(inc_c), .clr(clr), .cnt(cnt_c)
  );
  ds_sat_counter #(.CNT_W(CNT_W)) u_cnt_d (
    .clk(clk), .rst(rst), .inc(inc_d), .clr(clr), .cnt(cnt_d)
  );

endmodule

// File: tb/tb_four_bit_ds.sv
// Bench for four_bit_ds: an 8-bit and a 2-bit instance share stimulus and
// are checked each cycle against an array-based model plus literal checks.
module tb_four_bit_ds;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic E0 = 1'b0, E1 = 1'b0, en = 1'b0, clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  four_bit_ds_if #(.CNT_W(8)) bus ();
  four_bit_ds_if #(.CNT_W(2)) bus_s ();

  assign bus.A = A;    assign bus.B = B;    assign bus.C = C;    assign bus.D = D;
  assign bus.E0 = E0;  assign bus.E1 = E1;  assign bus.en = en;  assign bus.clr = clr;
  assign bus_s.A = A;  assign bus_s.B = B;  assign bus_s.C = C;  assign bus_s.D = D;
  assign bus_s.E0 = E0; assign bus_s.E1 = E1; assign bus_s.en = en; assign bus_s.clr = clr;

  four_bit_ds #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .A(bus.A), .B(bus.B), .C(bus.C), .D(bus.D),
    .E0(bus.E0), .E1(bus.E1), .en(bus.en), .clr(bus.clr),
    .F(bus.F), .F_q(bus.F_q), .sel_q(bus.sel_q), .sel_chg(bus.sel_chg),
    .cnt_a(bus.cnt_a), .cnt_b(bus.cnt_b), .cnt_c(bus.cnt_c), .cnt_d(bus.cnt_d)
  );

  four_bit_ds #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .A(bus_s.A), .B(bus_s.B), .C(bus_s.C), .D(bus_s.D),
    .E0(bus_s.E0), .E1(bus_s.E1), .en(bus_s.en), .clr(bus_s.clr),
    .F(bus_s.F), .F_q(bus_s.F_q), .sel_q(bus_s.sel_q), .sel_chg(bus_s.sel_chg),
    .cnt_a(bus_s.cnt_a), .cnt_b(bus_s.cnt_b), .cnt_c(bus_s.cnt_c), .cnt_d(bus_s.cnt_d)
  );

  // Reference model: channel data as an array indexed by select value.
  int m_fq, m_selq, m_chg;
  int m_cnt[4];
  int m_cnt_s[4];

  function automatic int sel_now();
    return int'(E0) * 2 + int'(E1);
  endfunction

  function automatic int mux_now();
    int data[4];
    data[0] = int'(A); data[1] = int'(B); data[2] = int'(C); data[3] = int'(D);
    return data[sel_now()];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fq = 0; m_selq = 0; m_chg = 0;
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_cnt_s[i] = 0; end
    end else begin
      int s;
      s = sel_now();
      m_fq   = mux_now();
      m_chg  = (s != m_selq) ? 1 : 0;
      m_selq = s;
      if (clr) begin
        for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_cnt_s[i] = 0; end
      end else if (en) begin
        if (m_cnt[s] < 255) m_cnt[s] = m_cnt[s] + 1;
        if (m_cnt_s[s] < 3) m_cnt_s[s] = m_cnt_s[s] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("F", int'(bus.F), mux_now());
    chk("F_q", int'(bus.F_q), m_fq);
    chk("sel_q", int'(bus.sel_q), m_selq);
    chk("sel_chg", int'(bus.sel_chg), m_chg);
    chk("cnt_a", int'(bus.cnt_a), m_cnt[0]);
    chk("cnt_b", int'(bus.cnt_b), m_cnt[1]);
    chk("cnt_c", int'(bus.cnt_c), m_cnt[2]);
    chk("cnt_d", int'(bus.cnt_d), m_cnt[3]);
    chk("s_F_q", int'(bus_s.F_q), m_fq);
    chk("s_sel_chg", int'(bus_s.sel_chg), m_chg);
    chk("s_cnt_a", int'(bus_s.cnt_a), m_cnt_s[0]);
    chk("s_cnt_b", int'(bus_s.cnt_b), m_cnt_s[1]);
    chk("s_cnt_c", int'(bus_s.cnt_c), m_cnt_s[2]);
    chk("s_cnt_d", int'(bus_s.cnt_d), m_cnt_s[3]);
  end

  task automatic mid();
    @(negedge clk);
    #2;
  endtask

  task automatic set_in(input logic [3:0] dcba, input logic [1:0] s);
    {D, C, B, A} = dcba;
    {E0, E1} = s;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_F_q", int'(bus.F_q), 0);
    chk("rst_sel_q", int'(bus.sel_q), 0);
    chk("rst_cnt_a", int'(bus.cnt_a), 0);
    mid(); rst = 1'b0;

    // Mux table and masking
    set_in(4'b0001, 2'b00); #1 chk("mux_A", int'(bus.F), 1);
    set_in(4'b0010, 2'b01); #1 chk("mux_B", int'(bus.F), 1);
    set_in(4'b0100, 2'b10); #1 chk("mux_C", int'(bus.F), 1);
    set_in(4'b1000, 2'b10); #1 chk("mux_D_sel_C", int'(bus.F), 0);
    set_in(4'b0001, 2'b11); #1 chk("mask_A", int'(bus.F), 0);
    set_in(4'b1001, 2'b11); #1 chk("mask_D", int'(bus.F), 1);

    // Registered path: 00 -> 11 with D=1
    mid(); set_in(4'b0000, 2'b00); clr = 1'b1;
    mid(); clr = 1'b0;
    mid(); set_in(4'b1000, 2'b11);
    @(posedge clk); #1;
    chk("reg_F_q", int'(bus.F_q), 1);
    chk("reg_sel_q", int'(bus.sel_q), 3);
    chk("reg_chg1", int'(bus.sel_chg), 1);
    @(posedge clk); #1;
    chk("reg_chg0", int'(bus.sel_chg), 0);

    // Counters: sel=10 for 5 edges, then clr with en
    mid(); set_in(4'b0000, 2'b10); en = 1'b1;
    repeat (5) @(posedge clk);
    #2 en = 1'b0;
    chk("cnt5_c", int'(bus.cnt_c), 5);
    chk("cnt5_a", int'(bus.cnt_a), 0);
    chk("cnt5_d", int'(bus.cnt_d), 0);
    mid(); en = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_c", int'(bus.cnt_c), 0);
    chk("clr_s_c", int'(bus_s.cnt_c), 0);
    mid(); clr = 1'b0; en = 1'b0;

    // Saturation on the 2-bit instance
    mid(); set_in(4'b0000, 2'b00); en = 1'b1;
    repeat (6) @(posedge clk);
    #2 en = 1'b0;
    chk("sat_s_a", int'(bus_s.cnt_a), 3);
    chk("sat_a8", int'(bus.cnt_a), 6);

    // Async reset between edges
    mid(); set_in(4'b0001, 2'b01); en = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_cnt_b", int'(bus.cnt_b), 0);
    chk("arst_cnt_a", int'(bus.cnt_a), 0);
    chk("arst_F_q", int'(bus.F_q), 0);
    chk("arst_sel_q", int'(bus.sel_q), 0);
    chk("arst_chg", int'(bus.sel_chg), 0);
    B = 1'b1; #1 chk("arst_F_tracks", int'(bus.F), 1);
    B = 1'b0; #1 chk("arst_F_tracks0", int'(bus.F), 0);
    mid(); rst = 1'b0; en = 1'b0;

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      mid();
      {D, C, B, A} = 4'($urandom);
      {E0, E1} = 2'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 1) begin
        #3 {D, C, B, A} = 4'($urandom);
        #1 chk("rand_F_mid", int'(bus.F), mux_now());
      end
    end
    mid(); rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
